uart_rx_fifo: RTL and testbench

Parametrised UART receive channel: oversamples the asynchronous `RX` line with a programmable bit-period divider, deframes start/data/(parity)/stop bits, and buffers received words in an internal FIFO read through a valid/ready interface. It is the next-generation receive path for `UART_top`. Compared with the fixed 8N1 receiver, it adds configurable word width, FIFO depth, false-start rejection, framing/overflow error reporting and optional parity.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_fifo_buf.sv | 61 ++++++
 rtl/uart_rx_fifo.sv | 176 +++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} rx_state_e;

   // Parity sense when parity is compiled in: 0 = even, 1 = odd.
   localparam logic PARITY_ODD = 1'b0;

   localparam int unsigned DEFAULT_CLK_DIV = 5000;

   // Width of a down-counter that must hold clk_div - 1.
   function automatic int unsigned calc_cnt_w(input int unsigned clk_div);
      return (clk_div < 2) ? 1 : $clog2(clk_div);
   endfunction

endpackage

// File: rtl/uart_rx_fifo_buf.sv
// Synchronous FIFO with a registered head word; dout/empty change on the edge after a push
// and on the same edge as a pop.
module uart_rx_fifo_buf #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             res,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] dout
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned PTR_W = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             push_ok, pop_ok;

   assign full    = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
   assign push_ok = push & (~full | pop_ok);
   assign pop_ok  = pop & valid_q;

   // The head register sees the old write pointer, so a fresh push shows up one edge later.
   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
      valid_d  = (wr_ptr_q != rd_ptr_d);
      dout_d   = valid_d ? mem_q[rd_ptr_d[AW-1:0]] : dout_q;
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q[AW-1:0]] <= din;
      end
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         valid_q  <= 1'b0;
         dout_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         valid_q  <= valid_d;
         dout_q   <= dout_d;
      end
   end

   assign empty = ~valid_q;
   assign dout  = dout_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with oversampling divider, false-start rejection and a receive FIFO.
// Define UART_RX_PARITY_EN to expect one parity bit per frame and enable parity_err.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned CLK_DIV    = DEFAULT_CLK_DIV,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 res,
   input  logic                 RX,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overflow
);

   localparam int unsigned CNT_W = calc_cnt_w(CLK_DIV);
   localparam int unsigned BIT_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_DIV / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

   logic                 rx_meta_q, rxs_q, rxs_prev_q;
   rx_state_e            state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 frame_err_q, frame_err_d, overflow_q, overflow_d;
   logic                 push, pop, full, empty, tick, fall;
`ifdef UART_RX_PARITY_EN
   logic                 par_q, par_d, par_bad_q, par_bad_d, parity_err_q, parity_err_d;
`endif

   assign tick = (cnt_q == '0);
   assign fall = rxs_prev_q & ~rxs_q;
   assign pop  = rx_valid & rx_ready;

   always_comb begin
      state_d     = state_q;
      cnt_d       = tick ? FULL_LOAD : cnt_q - CNT_W'(1);
      bit_d       = bit_q;
      shift_d     = shift_q;
      frame_err_d = 1'b0;
      overflow_d  = 1'b0;
      push        = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d        = par_q;
      par_bad_d    = par_bad_q;
      parity_err_d = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
            if (fall) begin
               state_d = StStart;
               cnt_d   = HALF_LOAD;
            end
         end
         StStart: begin
            if (tick) begin
               state_d = rxs_q ? StIdle : StData;
               bit_d   = '0;
`ifdef UART_RX_PARITY_EN
               par_d     = 1'b0;
               par_bad_d = 1'b0;
`endif
            end
         end
         StData: begin
            if (tick) begin
               shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
               par_d = par_q ^ rxs_q;
`endif
               if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         StParity: begin
            if (tick) begin
               par_bad_d = (rxs_q != (par_q ^ PARITY_ODD));
               state_d   = StStop;
            end
         end
`endif
         StStop: begin
            if (tick) begin
               state_d = StIdle;
               if (!rxs_q) begin
                  frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
               end else if (par_bad_q) begin
                  parity_err_d = 1'b1;
`endif
               end else if (full && !pop) begin
                  overflow_d = 1'b1;
               end else begin
                  push = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         rx_meta_q   <= 1'b1;
         rxs_q       <= 1'b1;
         rxs_prev_q  <= 1'b1;
         state_q     <= StIdle;
         cnt_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         rx_meta_q   <= RX;
         rxs_q       <= rx_meta_q;
         rxs_prev_q  <= rxs_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
         overflow_q  <= overflow_d;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         par_q        <= 1'b0;
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         par_q        <= par_d;
         par_bad_q    <= par_bad_d;
         parity_err_q <= parity_err_d;
      end
   end
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   uart_rx_fifo_buf #(
      .WIDTH(DATA_BITS),
      .DEPTH(FIFO_DEPTH)
   ) u_buf (
      .clk  (clk),
      .res  (res),
      .push (push),
      .pop  (pop),
      .din  (shift_q),
      .full (full),
      .empty(empty),
      .dout (rx_data)
   );

   assign rx_valid  = ~empty;
   assign frame_err = frame_err_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed frames, popped words checked by a monitor.
module tb_uart_rx_fifo;
   import uart_pkg::PARITY_ODD;

   localparam int unsigned CLK_DIV    = 16;
   localparam int unsigned DATA_BITS  = 8;
   localparam int unsigned FIFO_DEPTH = 4;
`ifdef UART_RX_PARITY_EN
   localparam int unsigned P = 1;
`else
   localparam int unsigned P = 0;
`endif
   localparam int unsigned LAT = 2 + 1 + CLK_DIV / 2 + (DATA_BITS + P + 1) * CLK_DIV + 1;

   logic                 clk = 1'b0;
   logic                 res = 1'b0;
   logic                 RX = 1'b1;
   logic                 rx_ready = 1'b1;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid, frame_err, parity_err, overflow;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          start_cyc = 0;
   int          first_cyc = -1;
   int          fe_cnt = 0, pe_cnt = 0, ov_cnt = 0;
   logic [7:0]  sb_q[$];

   uart_rx_fifo #(
      .CLK_DIV   (CLK_DIV),
      .DATA_BITS (DATA_BITS),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk       (clk),
      .res       (res),
      .RX        (RX),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .parity_err(parity_err),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: pops the scoreboard on every accepted word and counts error-pulse cycles.
   always @(negedge clk) begin
      if (res) begin
         if (frame_err) fe_cnt++;
         if (parity_err) pe_cnt++;
         if (overflow) ov_cnt++;
         if (rx_valid && first_cyc < 0) first_cyc = cyc;
         if (rx_valid && rx_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_pop got=%h exp=none", rx_data);
            end else begin
               logic [7:0] exp_w;
               exp_w = sb_q.pop_front();
               if (rx_data !== exp_w) begin
                  errors++;
                  $display("FAIL pop_data got=%h exp=%h", rx_data, exp_w);
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic drive_bit(input logic b);
      RX = b;
      repeat (CLK_DIV) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
      start_cyc = cyc;
      drive_bit(1'b0);
      for (int i = 0; i < int'(DATA_BITS); i++) drive_bit(d[i]);
      if (P == 1) drive_bit(^d ^ PARITY_ODD ^ par_flip);
      drive_bit(stop_b);
      if (!stop_b) drive_bit(1'b1);
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check(name, sb_q.size(), 0);
   endtask

   initial begin
      int c0;
      repeat (3) @(negedge clk);
      check("rst_valid", rx_valid, 0);
      check("rst_data", rx_data, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_parity_err", parity_err, 0);
      check("rst_overflow", overflow, 0);
      res = 1'b1;
      @(negedge clk);

      // Back-to-back frames with latency check on the first.
      sb_q.push_back(8'h09);
      sb_q.push_back(8'h06);
      sb_q.push_back(8'h0A);
      send_frame(8'h09, 1'b1, 1'b0);
      c0 = start_cyc;
      send_frame(8'h06, 1'b1, 1'b0);
      send_frame(8'h0A, 1'b1, 1'b0);
      wait_drain("b2b_drain");
      check("first_latency", first_cyc - c0, LAT);
      check("b2b_no_fe", fe_cnt, 0);
      check("b2b_no_ov", ov_cnt, 0);

      // Short low glitch must be rejected as a false start.
      RX = 1'b0;
      repeat (5) @(negedge clk);
      RX = 1'b1;
      repeat (3 * CLK_DIV) @(negedge clk);
      check("glitch_valid", rx_valid, 0);
      check("glitch_fe", fe_cnt, 0);

      // Framing error then a good frame.
      send_frame(8'h55, 1'b0, 1'b0);
      check("ferr_pulse", fe_cnt, 1);
      check("ferr_empty", rx_valid, 0);
      sb_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, 1'b0);
      wait_drain("ferr_next_drain");

      // Fill with consumer stalled; fifth word overflows.
      rx_ready = 1'b0;
      for (int v = 1; v <= 5; v++) begin
         if (v <= int'(FIFO_DEPTH)) sb_q.push_back(8'(v));
         send_frame(8'(v), 1'b1, 1'b0);
      end
      repeat (4) @(negedge clk);
      check("ovf_pulse", ov_cnt, 1);
      check("ovf_head_valid", rx_valid, 1);
      check("ovf_head_data", rx_data, 8'h01);
      repeat (20) @(negedge clk);
      check("ovf_head_stable", rx_data, 8'h01);
      rx_ready = 1'b1;
      wait_drain("ovf_drain");

      // Reset mid-frame with words queued.
      rx_ready = 1'b0;
      sb_q.push_back(8'h11);
      sb_q.push_back(8'h22);
      send_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0);
      drive_bit(1'b0);
      drive_bit(1'b0);
      drive_bit(1'b0);
      repeat (CLK_DIV / 2) @(negedge clk);
      check("pre_rst_valid", rx_valid, 1);
      res = 1'b0;
      #1;
      check("mid_rst_valid", rx_valid, 0);
      check("mid_rst_data", rx_data, 0);
      check("mid_rst_flags", {frame_err, parity_err, overflow}, 0);
      sb_q.delete();
      RX = 1'b1;
      repeat (5) @(negedge clk);
      res = 1'b1;
      rx_ready = 1'b1;
      sb_q.push_back(8'h7E);
      send_frame(8'h7E, 1'b1, 1'b0);
      wait_drain("post_rst_drain");

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b1);
      check("par_bad_pulse", pe_cnt, 1);
      check("par_bad_nopush", rx_valid, 0);
      sb_q.push_back(8'h07);
      send_frame(8'h07, 1'b1, 1'b0);
      wait_drain("par_good_drain");
      check("par_total", pe_cnt, 1);
`else
      check("par_tied_low", pe_cnt, 0);
`endif

      repeat (10) @(negedge clk);
      check("final_fe", fe_cnt, 1);
      check("final_ov", ov_cnt, 1);
      check("final_sb_empty", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
